uart_dtm_frame_rx: RTL and testbench

Upstream stage of the UART DTM. Consumes the raw byte stream from the UART receiver, finds frame starts (HEADER = 0x01), decodes the command byte into cmd_e/addr_e, de-escapes and assembles write payloads, and hands one complete command to the DTM core per valid/ready handshake. Malformed, truncated or stalled frames are dropped and flagged so the DTM never sees partial data.

---
 rtl/uart_pkg.sv | 65 ++++++
 rtl/uart_dtm_frame_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_dtm_frame_rx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART DTM. It holds the command and
// address encodings, the framing bytes, the parser states and the payload-length
// helpers. It has no ports; it is imported by the frame parser.
package uart_pkg;

  // Command byte layout: cmd in the top three bits, addr in the low five.
  localparam int CMD_BYTE_CMD_MSB  = 7;
  localparam int CMD_BYTE_CMD_LSB  = 5;
  localparam int CMD_BYTE_ADDR_MSB = 4;
  localparam int CMD_BYTE_ADDR_LSB = 0;

  localparam logic [7:0] HEADER = 8'h01;
  localparam logic [7:0] ESC    = 8'hA0;

  // DMI write word: 7 address bits + 32 data bits + 2 op bits.
  localparam int WLEN_DMI   = 41;
  localparam int MAX_WBYTES = 6;

  // Codes 3'b100..3'b110 are reserved and rejected by the parser.
  typedef enum logic [2:0] {
    CMD_NOP       = 3'b000,
    CMD_READ      = 3'b001,
    CMD_CONT_READ = 3'b010,
    CMD_WRITE     = 3'b011,
    CMD_RESET     = 3'b111
  } cmd_e;

  typedef enum logic [4:0] {
    ADDR_NOP     = 5'h00,
    ADDR_IDCODE  = 5'h01,
    ADDR_DTMCS   = 5'h10,
    ADDR_DMI     = 5'h11,
    ADDR_STB0_CS = 5'h14,
    ADDR_STB0_D  = 5'h15,
    ADDR_STB1_CS = 5'h16,
    ADDR_STB1_D  = 5'h17
  } addr_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    ESCP,
    OUT
  } frame_state_e;

  // Number of payload bits a write to this register carries.
  function automatic int get_write_length(input logic [4:0] addr);
    int len;
    case (addr)
      ADDR_IDCODE, ADDR_DTMCS:   len = 32;
      ADDR_DMI:                  len = WLEN_DMI;
      ADDR_STB0_D, ADDR_STB1_D:  len = 32;
      ADDR_STB0_CS, ADDR_STB1_CS: len = 8;
      default:                   len = 8;
    endcase
    return len;
  endfunction

  // Payload bytes on the wire for a write to this register.
  function automatic logic [2:0] get_write_bytes(input logic [4:0] addr);
    return 3'((get_write_length(addr) + 7) / 8);
  endfunction

endpackage

// File: rtl/uart_dtm_frame_rx.sv
// uart_dtm_frame_rx: finds HEADER-delimited frames in the UART byte stream,
// decodes the command byte, de-escapes write payloads and presents one complete
// command per valid/ready handshake; malformed or stalled frames pulse frame_err_o.
// Ports: rx_data_i/rx_valid_i/rx_ready_o byte input; cmd_o/addr_o/data_o with
// cmd_valid_o/cmd_ready_i command output; frame_err_o drop pulse; clk_i, rst_i.
module uart_dtm_frame_rx
  import uart_pkg::*;
#(
  parameter int DATA_W         = 48,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [2:0]        cmd_o,
  output logic [4:0]        addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic              frame_err_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  frame_state_e      state, state_n;
  logic [2:0]        cnt, cnt_n;    // payload bytes still expected
  logic [2:0]        idx, idx_n;    // next payload byte slot
  logic [DATA_W-1:0] data, data_n;
  logic [2:0]        cmd, cmd_n;
  logic [4:0]        addr, addr_n;
  logic              err_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic              xfer;
  logic              store;
  logic              tmo_hit;
  logic [2:0]        rx_cmd;
  logic [4:0]        rx_addr;

  // Ready drops combinationally during reset so no byte is lost to a reset edge.
  assign rx_ready_o  = !rst_i && (state != OUT);
  assign xfer        = rx_valid_i && rx_ready_o;
  assign cmd_valid_o = (state == OUT);
  assign cmd_o       = cmd;
  assign addr_o      = addr;
  assign data_o      = data;

  assign rx_cmd  = rx_data_i[CMD_BYTE_CMD_MSB:CMD_BYTE_CMD_LSB];
  assign rx_addr = rx_data_i[CMD_BYTE_ADDR_MSB:CMD_BYTE_ADDR_LSB];

  // Fires on the idle cycle that would bring the count up to TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && !xfer &&
                   (tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    cmd_n   = cmd;
    addr_n  = addr;
    err_n   = 1'b0;
    tmo_n   = tmo;
    store   = 1'b0;

    case (state)
      IDLE: begin
        tmo_n = '0;
        if (xfer && rx_data_i == HEADER) state_n = CMD;
      end
      CMD: begin
        // A repeated HEADER simply resynchronises; stay here.
        if (xfer && rx_data_i != HEADER) begin
          case (cmd_e'(rx_cmd))
            CMD_WRITE: begin
              cmd_n   = rx_cmd;
              addr_n  = rx_addr;
              cnt_n   = get_write_bytes(rx_addr);
              idx_n   = '0;
              data_n  = '0;
              state_n = DATA;
            end
            CMD_NOP, CMD_READ, CMD_CONT_READ, CMD_RESET: begin
              cmd_n   = rx_cmd;
              addr_n  = rx_addr;
              data_n  = '0;
              state_n = OUT;
            end
            default: begin
              err_n   = 1'b1;
              state_n = IDLE;
            end
          endcase
        end
      end
      DATA: begin
        if (xfer) begin
          if (rx_data_i == ESC) begin
            state_n = ESCP;
          end else if (rx_data_i == HEADER) begin
            // Unescaped HEADER means the sender restarted: drop and resync.
            err_n   = 1'b1;
            state_n = CMD;
          end else begin
            store = 1'b1;
          end
        end
      end
      ESCP: begin
        if (xfer) store = 1'b1;
      end
      OUT: begin
        tmo_n = '0;
        if (cmd_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (store) begin
      for (int i = 0; i < MAX_WBYTES; i++) begin
        if (idx == 3'(i)) data_n[8*i +: 8] = rx_data_i;
      end
      idx_n   = idx + 3'd1;
      cnt_n   = cnt - 3'd1;
      state_n = (cnt == 3'd1) ? OUT : DATA;
    end

    // Inter-byte timeout, only while a frame is open.
    if (state == CMD || state == DATA || state == ESCP) begin
      if (xfer) begin
        tmo_n = '0;
      end else if (tmo_hit) begin
        tmo_n   = '0;
        err_n   = 1'b1;
        state_n = IDLE;
      end else if (TIMEOUT_CYCLES != 0) begin
        tmo_n = tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data        <= '0;
      cmd         <= CMD_NOP;
      addr        <= ADDR_NOP;
      tmo         <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      data        <= data_n;
      cmd         <= cmd_n;
      addr        <= addr_n;
      tmo         <= tmo_n;
      frame_err_o <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_dtm_frame_rx.sv
// Bench for uart_dtm_frame_rx: directed frame vectors plus hand-written
// sequences for output hold, inter-byte timeout and mid-frame reset.
module tb_uart_dtm_frame_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [2:0]  cmd;
  logic [4:0]  addr;
  logic [47:0] data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        frame_err;

  always #5 clk = ~clk;

  uart_dtm_frame_rx #(.DATA_W(48), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .cmd_o(cmd), .addr_o(addr), .data_o(data),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .frame_err_o(frame_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: counts handshakes and error pulses, records each delivered command.
  int n_hs  = 0;
  int n_err = 0;
  logic [55:0] hs_q[$];
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      n_hs++;
      hs_q.push_back({cmd, addr, data});
    end
    if (frame_err) n_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte: byte %0h not accepted in 50 cycles, required accept", b);
    end
  endtask

  task automatic quiet_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  typedef struct {
    int            n;
    logic [0:9][7:0] b;
    int            hs;
    int            err;
    logic [2:0]    cmd;
    logic [4:0]    addr;
    logic [47:0]   data;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  int base_hs, base_err, first_err;
  logic held_ok;
  logic [55:0] rec;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // READ DTMCS
    vecs[0] = '{2, {8'h01, 8'h30, 64'h0}, 1, 0, 3'd1, 5'h10, 48'h0};
    // DMI write aborted by unescaped HEADER; parser resyncs in CMD and takes 0x30
    vecs[1] = '{9, {8'h01, 8'h71, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h01, 8'h30, 8'h00},
                1, 1, 3'd1, 5'h10, 48'h0};
    // DMI write with escaped HEADER as last byte
    vecs[2] = '{9, {8'h01, 8'h71, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hA0, 8'h01, 8'h00},
                1, 0, 3'd3, 5'h11, 48'h01_55_44_33_22_11};
    // STB0_CS write takes one byte; trailing 0x55 is dropped in IDLE, then a READ
    vecs[3] = '{7, {8'h01, 8'h74, 8'hA0, 8'hA0, 8'h55, 8'h01, 8'h30, 24'h0},
                2, 0, 3'd3, 5'h14, 48'h0000_0000_00A0};
    // garbage, double HEADER, RESET
    vecs[4] = '{5, {8'hFF, 8'h33, 8'h01, 8'h01, 8'hE0, 40'h0}, 1, 0, 3'd7, 5'h00, 48'h0};
    // reserved command 3'b100
    vecs[5] = '{2, {8'h01, 8'h90, 64'h0}, 0, 1, 3'd0, 5'h00, 48'h0};
    // reserved command 3'b110
    vecs[6] = '{2, {8'h01, 8'hC1, 64'h0}, 0, 1, 3'd0, 5'h00, 48'h0};
    // CONT_READ DMI
    vecs[7] = '{2, {8'h01, 8'h51, 64'h0}, 1, 0, 3'd2, 5'h11, 48'h0};
    // DMI write with escaped HEADER and escaped ESC
    vecs[8] = '{10, {8'h01, 8'h71, 8'hA0, 8'h01, 8'hA0, 8'hA0, 8'h33, 8'h44, 8'h55, 8'h66},
                1, 0, 3'd3, 5'h11, 48'h66_55_44_33_A0_01};
    // IDCODE write, four bytes
    vecs[9] = '{6, {8'h01, 8'h61, 8'h11, 8'h22, 8'h33, 8'h44, 32'h0},
                1, 0, 3'd3, 5'h01, 48'h0000_4433_2211};

    // ---- reset state ----
    rst = 1'b1;
    @(negedge clk);
    check("rst_rx_ready_in_reset", 64'(rx_ready), 64'd0);
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_rx_ready_after", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;

    // ---- vector table ----
    for (int v = 0; v < NV; v++) begin
      quiet_reset();
      base_hs  = n_hs;
      base_err = n_err;
      for (int j = 0; j < vecs[v].n; j++) send_byte(vecs[v].b[j]);
      cycles(4);
      check($sformatf("vec%0d_handshakes", v), 64'(n_hs - base_hs), 64'(vecs[v].hs));
      check($sformatf("vec%0d_errors", v), 64'(n_err - base_err), 64'(vecs[v].err));
      if (vecs[v].hs > 0 && n_hs > base_hs) begin
        rec = hs_q[base_hs];
        check($sformatf("vec%0d_cmd", v), 64'(rec[55:53]), 64'(vecs[v].cmd));
        check($sformatf("vec%0d_addr", v), 64'(rec[52:48]), 64'(vecs[v].addr));
        check($sformatf("vec%0d_data", v), 64'(rec[47:0]), 64'(vecs[v].data));
      end
    end

    // ---- output held while DTM stalls; timeout idle in OUT ----
    quiet_reset();
    cmd_ready = 1'b0;
    base_hs  = n_hs;
    base_err = n_err;
    send_byte(8'h01);
    send_byte(8'h30);
    @(negedge clk);
    check("hold_latency_valid", 64'(cmd_valid), 64'd1);
    check("hold_cmd", 64'(cmd), 64'd1);
    check("hold_addr", 64'(addr), 64'h10);
    held_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(cmd_valid === 1'b1 && rx_ready === 1'b0 && cmd === 3'd1 &&
            addr === 5'h10 && data === 48'h0))
        held_ok = 1'b0;
    end
    check("hold_stable_20_cycles", 64'(held_ok), 64'd1);
    check("hold_no_timeout_in_out", 64'(n_err - base_err), 64'd0);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_valid_dropped", 64'(cmd_valid), 64'd0);
    check("hold_rx_ready_back", 64'(rx_ready), 64'd1);
    check("hold_one_handshake", 64'(n_hs - base_hs), 64'd1);
    @(posedge clk);
    #1;

    // ---- inter-byte timeout during IDCODE write ----
    quiet_reset();
    base_hs  = n_hs;
    base_err = n_err;
    send_byte(8'h01);
    send_byte(8'h61);
    send_byte(8'h11);
    send_byte(8'h22);
    first_err = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (frame_err && first_err == 0) first_err = k;
      @(posedge clk);
      #1;
    end
    check("timeout_pulse_cycle", 64'(first_err), 64'd17);
    check("timeout_single_pulse", 64'(n_err - base_err), 64'd1);
    // Back in IDLE: bare 0x30 is discarded, then a proper READ frame.
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h30);
    cycles(3);
    check("timeout_then_one_cmd", 64'(n_hs - base_hs), 64'd1);
    if (n_hs > base_hs) begin
      rec = hs_q[base_hs];
      check("timeout_then_cmd_word", 64'(rec), {8'h0, 3'd1, 5'h10, 48'h0});
    end

    // ---- reset in the middle of a DMI write ----
    quiet_reset();
    base_hs  = n_hs;
    base_err = n_err;
    send_byte(8'h01);
    send_byte(8'h71);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_ready_in_reset", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("midrst_cmd", 64'(cmd), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_data", 64'(data), 64'd0);
    check("midrst_rx_ready", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1;
    send_byte(8'h01);
    send_byte(8'h30);
    cycles(3);
    check("midrst_no_error", 64'(n_err - base_err), 64'd0);
    check("midrst_then_one_cmd", 64'(n_hs - base_hs), 64'd1);
    if (n_hs > base_hs) begin
      rec = hs_q[base_hs];
      check("midrst_then_cmd_word", 64'(rec), {8'h0, 3'd1, 5'h10, 48'h0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
